input_conditioner: RTL

//  Cleans the raw board inputs (4 slide switches, 2 push buttons) before they reach the

---
 rtl/input_conditioner.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Board input conditioner: per-channel 2-flop sync, counter debounce, button press pulses.
// Optional auto-repeat on held buttons when BTN_REPEAT_EN is defined.
module input_conditioner #(
    parameter int N_SW            = 4,
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw_in,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_SW-1:0]  sw_out,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int N_CH = N_SW + N_BTN;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("input_conditioner: illegal timing parameters");
    end

    // Switches occupy the low channels, buttons the high ones; all are 1 = active here.
    logic [N_BTN-1:0]         btn_norm;
    logic [N_CH-1:0]          raw;
    logic [N_CH-1:0]          meta_q, sync_q;
    logic [N_CH-1:0]          stable_q, stable_d;
    logic [N_CH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [N_BTN-1:0]         btn_stable;

    assign btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_in : btn_in;
    assign raw      = {btn_norm, sw_in};

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_stable = stable_q[N_CH-1 -: N_BTN];
    assign sw_out     = stable_q[N_SW-1:0];
    assign btn_level  = btn_stable;

`ifdef BTN_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

    for (genvar b = 0; b < N_BTN; b++) begin : g_rep
        rep_state_e     state_q;
        logic [RW-1:0]  rep_cnt_q;
        logic           pulse_q;

        // A release (stable low) overrides every state so no pulse escapes after it.
        always_ff @(posedge clk) begin
            if (reset || !btn_stable[b]) begin
                state_q   <= IDLE;
                rep_cnt_q <= '0;
                pulse_q   <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        pulse_q   <= 1'b1;
                        rep_cnt_q <= '0;
                        state_q   <= DELAY;
                    end
                    DELAY: begin
                        if (rep_cnt_q == DELAY_LAST) begin
                            pulse_q   <= 1'b1;
                            rep_cnt_q <= '0;
                            state_q   <= REPEAT;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rep_cnt_q == PERIOD_LAST) begin
                            pulse_q   <= 1'b1;
                            rep_cnt_q <= '0;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign btn_pulse[b] = pulse_q;
    end
`else
    logic [N_BTN-1:0] prev_q, pulse_q, pulse_d;

    always_comb pulse_d = btn_stable & ~prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            prev_q  <= btn_stable;
            pulse_q <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;
`endif

endmodule
